// File: rtl/adc_spi_if.sv
// ---------------------------------------------------------------------------
// adc_spi_if
// Signal bundle between the ADC serial capture front-end and its surroundings
// (acquisition controller on one side, the ADC's SPI/convert pins on the
// other).
//
//   adc_trig  controller -> front-end   one-cycle conversion request
//   adc_done  front-end  -> controller  one-cycle "samples valid" pulse
//   adc_a     front-end  -> controller  channel A sample, two's complement
//   adc_b     front-end  -> controller  channel B sample, two's complement
//   busy      front-end  -> controller  conversion in progress
//   ad_conv   front-end  -> ADC         conversion start strobe
//   spi_sck   front-end  -> ADC         serial clock, idles low
//   spi_miso  ADC        -> front-end   serial data
//
// modport slave  : the capture front-end (adc_spi)
// modport master : everything around it (controller plus ADC pins)
// ---------------------------------------------------------------------------
interface adc_spi_if;
    logic               adc_trig;
    logic               adc_done;
    logic signed [13:0] adc_a;
    logic signed [13:0] adc_b;
    logic               busy;
    logic               ad_conv;
    logic               spi_sck;
    logic               spi_miso;

    modport slave (
        input  adc_trig, spi_miso,
        output adc_done, adc_a, adc_b, busy, ad_conv, spi_sck
    );

    modport master (
        output adc_trig, spi_miso,
        input  adc_done, adc_a, adc_b, busy, ad_conv, spi_sck
    );
endinterface

// File: rtl/adc_spi.sv
// ---------------------------------------------------------------------------
// adc_spi
// Serial capture front-end for the dual-channel 14-bit ADC. On a trigger it
// pulses the conversion strobe for one SCK period, clocks out a 34-bit frame
// (MSB first) and deserialises channel A (frame bits 2..15) and channel B
// (frame bits 18..31). The parallel samples are published, together with a
// one-cycle adc_done, only once the whole frame has been received.
//
// Ports
//   CLK50MHZ  system clock
//   RST       asynchronous, active-low reset
//   bus       adc_spi_if.slave (trigger/done/samples/busy, ad_conv/SCK/MISO)
//
// Parameters
//   DIV    SCK half-period in CLK50MHZ cycles (>= 1)
//   FRAME  SCK cycles per conversion frame
// ---------------------------------------------------------------------------
module adc_spi #(
    parameter int DIV   = 2,
    parameter int FRAME = 34
) (
    input  logic     CLK50MHZ,
    input  logic     RST,
    adc_spi_if.slave bus
);
    localparam int               DIV_W     = $clog2(DIV) + 1;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] CONV_LAST = DIV_W'(2 * DIV - 1);
    localparam logic [5:0]       BIT_END   = 6'(FRAME);
    localparam logic [5:0]       A_FIRST   = 6'd2;
    localparam logic [5:0]       A_LAST    = 6'd15;
    localparam logic [5:0]       B_FIRST   = 6'd18;
    localparam logic [5:0]       B_LAST    = 6'd31;

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         bit_cnt;
    logic               sck;
    logic [13:0]        sh_a;
    logic [13:0]        sh_b;
    logic signed [13:0] a_q;
    logic signed [13:0] b_q;
    logic               half_end;
    logic               conv_end;
    logic               frame_end;
    logic               sck_rise;

    assign half_end  = (div_cnt == HALF_LAST);
    assign conv_end  = (div_cnt == CONV_LAST);
    // bit_cnt counts completed SCK periods; reaching FRAME leaves one
    // trailing low-SCK cycle before DONE
    assign frame_end = (bit_cnt == BIT_END);
    // edge on which SCK goes 0->1; bit_cnt then equals the frame bit index k
    assign sck_rise  = (state == SHIFT) && !frame_end && half_end && !sck;

    assign bus.spi_sck = sck;
    assign bus.adc_a   = a_q;
    assign bus.adc_b   = b_q;

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.ad_conv  = 1'b0;
        bus.adc_done = 1'b0;
        bus.busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.adc_trig) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                bus.ad_conv = 1'b1;
                if (conv_end) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (frame_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.adc_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // SCK divider, bit counter and published samples
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state)
                CONV: begin
                    div_cnt <= conv_end ? '0 : div_cnt + 1'b1;
                end
                SHIFT: begin
                    if (frame_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        a_q     <= sh_a;
                        b_q     <= sh_b;
                    end else if (half_end) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (sck) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sck     <= 1'b0;
                end
            endcase
        end
    end

    // Deserialisers: only the bit windows belonging to each channel shift in
    always_ff @(posedge CLK50MHZ) begin
        if (sck_rise && (bit_cnt >= A_FIRST) && (bit_cnt <= A_LAST)) begin
            sh_a <= {sh_a[12:0], bus.spi_miso};
        end
        if (sck_rise && (bit_cnt >= B_FIRST) && (bit_cnt <= B_LAST)) begin
            sh_b <= {sh_b[12:0], bus.spi_miso};
        end
    end
endmodule
